// File: rtl/clint_timer_responder.sv
// rtl/clint_timer_responder.sv - bus responder for machine timer compare, mtime snapshot and MSIP
module clint_timer_responder #(
  parameter int                ADDR_W    = 5,
  parameter int                CODE_W    = 4,
  parameter logic [CODE_W-1:0] SOFT_CODE = CODE_W'(3),
  parameter logic [31:0]       CMP_RST   = 32'hFFFF_FFFF
) (
  input  logic              clk_timer,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic [31:0]       mtime_low,
  input  logic [31:0]       mtime_high,
  output logic [31:0]       mtimecmp_low,
  output logic [31:0]       mtimecmp_high,
  output logic              set_mtimecmp_low,
  output logic              set_mtimecmp_high,
  output logic [CODE_W-1:0] soft_int_code
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, RESP} state_t;

  state_t      state;
  logic        msip;
  logic        snap_v;
  logic        pend_high;
  logic [31:0] snap;

  logic is_lo, is_hi, is_cl, is_ch, is_ms, hit, err, cmp_wr;

  // Exact offset compares also reject misaligned addresses.
  assign is_lo  = (req_addr == ADDR_W'('h00));
  assign is_hi  = (req_addr == ADDR_W'('h04));
  assign is_cl  = (req_addr == ADDR_W'('h08));
  assign is_ch  = (req_addr == ADDR_W'('h0C));
  assign is_ms  = (req_addr == ADDR_W'('h10));
  assign hit    = is_lo | is_hi | is_cl | is_ch | is_ms;
  assign err    = !hit || (req_we && (is_lo || is_hi));
  assign cmp_wr = req_we && (is_cl || is_ch);

  assign req_ready     = (state == IDLE);
  assign soft_int_code = msip ? SOFT_CODE : '0;

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      resp_err          <= 1'b0;
      mtimecmp_low      <= CMP_RST;
      mtimecmp_high     <= CMP_RST;
      set_mtimecmp_low  <= 1'b0;
      set_mtimecmp_high <= 1'b0;
      msip              <= 1'b0;
      snap              <= '0;
      snap_v            <= 1'b0;
      pend_high         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (cmp_wr) begin
              if (is_ch) mtimecmp_high <= req_wdata;
              else       mtimecmp_low  <= req_wdata;
              pend_high <= is_ch;
              state     <= SETUP;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= err;
              resp_rdata <= '0;
              state      <= RESP;
              if (!err) begin
                if (req_we) begin
                  msip <= req_wdata[0];
                end else if (is_lo) begin
                  resp_rdata <= mtime_low;
                  snap       <= mtime_high;
                  snap_v     <= 1'b1;
                end else if (is_hi) begin
                  resp_rdata <= snap_v ? snap : mtime_high;
                  snap_v     <= 1'b0;
                end else if (is_cl) begin
                  resp_rdata <= mtimecmp_low;
                end else if (is_ch) begin
                  resp_rdata <= mtimecmp_high;
                end else begin
                  resp_rdata <= {31'b0, msip};
                end
              end
            end
          end
        end
        SETUP: begin
          set_mtimecmp_high <= pend_high;
          set_mtimecmp_low  <= !pend_high;
          state             <= PULSE;
        end
        PULSE: begin
          set_mtimecmp_low  <= 1'b0;
          set_mtimecmp_high <= 1'b0;
          resp_valid        <= 1'b1;
          resp_rdata        <= '0;
          resp_err          <= 1'b0;
          state             <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer_responder.sv
// tb/tb_clint_timer_responder.sv - randomized bench with a transaction-level timer responder model
module tb_clint_timer_responder;

  logic        clk_timer = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [63:0] mt = '0;
  logic        req_ready, resp_valid, resp_err, set_mtimecmp_low, set_mtimecmp_high;
  logic [31:0] resp_rdata, mtimecmp_low, mtimecmp_high;
  logic [3:0]  soft_int_code;

  always #5 clk_timer = ~clk_timer;

  clint_timer_responder dut (
    .clk_timer(clk_timer), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mtime_low(mt[31:0]), .mtime_high(mt[63:32]),
    .mtimecmp_low(mtimecmp_low), .mtimecmp_high(mtimecmp_high),
    .set_mtimecmp_low(set_mtimecmp_low), .set_mtimecmp_high(set_mtimecmp_high),
    .soft_int_code(soft_int_code)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model state plus the per-cycle bus expectations.
  logic [31:0] m_cmp_lo = 32'hFFFF_FFFF, m_cmp_hi = 32'hFFFF_FFFF, m_snap = '0;
  bit          m_snap_v = 0, m_msip = 0;
  bit          e_ready = 1, e_rv = 0, e_sl = 0, e_sh = 0, e_err = 0;
  logic [31:0] e_rdata = '0;
  bit          chk_en = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_timer) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
      chk("set_lo", {31'b0, set_mtimecmp_low}, {31'b0, e_sl});
      chk("set_hi", {31'b0, set_mtimecmp_high}, {31'b0, e_sh});
      chk("cmp_lo", mtimecmp_low, m_cmp_lo);
      chk("cmp_hi", mtimecmp_high, m_cmp_hi);
      chk("soft_code", {28'b0, soft_int_code}, m_msip ? 32'd3 : 32'd0);
      if (e_rv) begin
        chk("rdata", resp_rdata, e_rdata);
        chk("err", {31'b0, resp_err}, {31'b0, e_err});
      end
    end
  end

  task automatic tick();
    @(posedge clk_timer);
    #1;
  endtask

  task automatic model_reset();
    m_cmp_lo = 32'hFFFF_FFFF; m_cmp_hi = 32'hFFFF_FFFF;
    m_snap = '0; m_snap_v = 0; m_msip = 0;
    e_ready = 1; e_rv = 0; e_sl = 0; e_sh = 0;
  endtask

  task automatic access(input logic we, input logic [4:0] a, input logic [31:0] wd, input int hold);
    bit          err, cmpw;
    logic [31:0] rd;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; resp_ready = 0;
    tick();
    req_valid = 0;
    err  = (a[1:0] != 2'b00) || (a > 5'h10) || (we && a <= 5'h04);
    cmpw = !err && we && (a == 5'h08 || a == 5'h0C);
    rd   = '0;
    if (!err) begin
      if (we) begin
        if (a == 5'h08) m_cmp_lo = wd;
        else if (a == 5'h0C) m_cmp_hi = wd;
        else m_msip = wd[0];
      end else begin
        case (a)
          5'h00: begin rd = mt[31:0]; m_snap = mt[63:32]; m_snap_v = 1; end
          5'h04: begin rd = m_snap_v ? m_snap : mt[63:32]; m_snap_v = 0; end
          5'h08: rd = m_cmp_lo;
          5'h0C: rd = m_cmp_hi;
          default: rd = {31'b0, m_msip};
        endcase
      end
    end
    e_ready = 0;
    if (cmpw) begin
      tick();
      e_sl = (a == 5'h08); e_sh = (a == 5'h0C);
      tick();
      e_sl = 0; e_sh = 0;
    end
    e_rv = 1; e_rdata = rd; e_err = err;
    last_rdata = resp_rdata; last_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      mt = mt + 64'($urandom_range(0, 5));
      tick();
    end
    req_valid = 0;
    resp_ready = 1;
    tick();
    resp_ready = 0; e_rv = 0; e_ready = 1;
  endtask

  initial begin
    logic        we;
    logic [4:0]  a;

    #22;
    chk("rst_cmp_lo", mtimecmp_low, 32'hFFFF_FFFF);
    chk("rst_cmp_hi", mtimecmp_high, 32'hFFFF_FFFF);
    chk("rst_strobes", {30'b0, set_mtimecmp_low, set_mtimecmp_high}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_soft", {28'b0, soft_int_code}, 32'd0);
    #6 rst = 1;
    tick();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk_en = 1;

    access(1, 5'h08, 32'h0000_0100, 0);
    chk("wr_cmp_lo", mtimecmp_low, 32'h0000_0100);
    chk("wr_cmp_err", {31'b0, last_err}, 32'd0);

    mt = 64'h0000_0001_FFFF_FFFF;
    access(0, 5'h00, 0, 0);
    chk("snap_lo", last_rdata, 32'hFFFF_FFFF);
    mt = 64'h0000_0002_0000_0000;
    access(0, 5'h04, 0, 0);
    chk("snap_hi", last_rdata, 32'h0000_0001);
    access(0, 5'h04, 0, 0);
    chk("live_hi", last_rdata, 32'h0000_0002);

    access(1, 5'h10, 32'h1, 0);
    chk("msip_code", {28'b0, soft_int_code}, 32'd3);
    access(0, 5'h10, 0, 0);
    chk("msip_read", last_rdata, 32'd1);
    access(1, 5'h10, 32'h0, 0);
    chk("msip_clear", {28'b0, soft_int_code}, 32'd0);

    mt = 64'h0000_0007_0000_AAAA;
    access(0, 5'h00, 0, 0);
    mt = 64'h0000_0009_0000_0000;
    access(1, 5'h00, 32'h55, 0);
    chk("err_wr0", {31'b0, last_err}, 32'd1);
    access(0, 5'h14, 0, 0);
    chk("err_14", {31'b0, last_err}, 32'd1);
    access(0, 5'h0A, 0, 0);
    chk("err_0a", {31'b0, last_err}, 32'd1);
    chk("err_rdata", last_rdata, 32'd0);
    access(0, 5'h04, 0, 0);
    chk("snap_kept", last_rdata, 32'h0000_0007);

    access(0, 5'h08, 0, 5);

    // Reset while the high-half strobe is up.
    req_valid = 1; req_we = 1; req_addr = 5'h0C; req_wdata = 32'h1234_5678;
    tick();
    req_valid = 0; chk_en = 0;
    tick();
    chk("pulse_hi", {31'b0, set_mtimecmp_high}, 32'd1);
    #2 rst = 0;
    #1;
    chk("abort_strobe", {30'b0, set_mtimecmp_low, set_mtimecmp_high}, 32'd0);
    chk("abort_cmp_hi", mtimecmp_high, 32'hFFFF_FFFF);
    chk("abort_resp", {31'b0, resp_valid}, 32'd0);
    model_reset();
    #3 rst = 1;
    tick();
    chk_en = 1;
    repeat (4) tick();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) mt = {$urandom, $urandom};
      else mt = mt + 64'($urandom_range(0, 3000));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = 5'($urandom_range(0, 4) * 4);
      else a = 5'($urandom_range(0, 31));
      access(we, a, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tick();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
